// File: rtl/ysyx_23060286_mem_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one outstanding transaction.
// Define YSYX_23060286_ARB_RR_EN for round-robin tie-break; default is fixed LSU priority.
module ysyx_23060286_mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_addr,
    output logic            ifu_resp_valid,
    output logic [DW-1:0]   ifu_rdata,
    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_addr,
    input  logic            lsu_wen,
    input  logic [DW-1:0]   lsu_wdata,
    input  logic [DW/8-1:0] lsu_wstrb,
    output logic            lsu_resp_valid,
    output logic [DW-1:0]   lsu_rdata,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_wen,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_rdata,
    output logic            grant_lsu
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t state;
    logic   accept;
    logic   pick_lsu;
    logic   resp_fire;

    // rst wins over any handshake in the same cycle
    assign accept    = (state == IDLE) && (ifu_req_valid || lsu_req_valid) && !rst;
    assign resp_fire = (state == WAIT) && mem_resp_valid && !rst;

`ifdef YSYX_23060286_ARB_RR_EN
    logic last_lsu;

    always_comb begin
        pick_lsu = lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid)
            pick_lsu = !last_lsu;
    end

    // resets to LSU so that IFU takes the first tie
    always_ff @(posedge clk) begin
        if (rst)
            last_lsu <= 1'b1;
        else if (accept)
            last_lsu <= pick_lsu;
    end
`else
    assign pick_lsu = lsu_req_valid;
`endif

    assign ifu_req_ready  = accept && !pick_lsu;
    assign lsu_req_ready  = accept && pick_lsu;
    assign ifu_resp_valid = resp_fire && !grant_lsu;
    assign lsu_resp_valid = resp_fire && grant_lsu;
    assign ifu_rdata      = grant_lsu ? '0 : mem_rdata;
    assign lsu_rdata      = grant_lsu ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            grant_lsu     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state         <= REQ;
                        mem_req_valid <= 1'b1;
                        grant_lsu     <= pick_lsu;
                        if (pick_lsu) begin
                            mem_addr  <= lsu_addr;
                            mem_wen   <= lsu_wen;
                            mem_wdata <= lsu_wdata;
                            mem_wstrb <= lsu_wstrb;
                        end else begin
                            mem_addr  <= ifu_addr;
                            mem_wen   <= 1'b0;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                REQ: begin
                    // responses seen here are early and deliberately dropped
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid)
                        state <= IDLE;
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/ysyx_23060286_mem_arbiter.md
# ysyx_23060286_mem_arbiter

Two-master, one-slave memory arbiter that lets the instruction fetch path and the load/store path of the ysyx_23060286 core share a single memory port. Sits between the core datapath (fetch address from PC, load/store address/data/strobe from ALU result, rs2 data and memwrite) and the memory/bus model. Runs one outstanding transaction at a time through a three-state FSM, with registered request capture and a valid/ready handshake on every side.

## Interface
- AW, 32, address width
- DW, 32, data width; strobe width is DW/8

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  AW  fetch address
- ifu_resp_valid  out  1  fetch data valid, one-cycle pulse
- ifu_rdata  out  DW  fetch data
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_addr  in  AW  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DW  store data
- lsu_wstrb  in  DW/8  byte strobes (store only)
- lsu_resp_valid  out  1  load data / store done, one-cycle pulse
- lsu_rdata  out  DW  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr, mem_wen, mem_wdata, mem_wstrb  out  AW/1/DW/DW/8  captured request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DW  memory read data
- grant_lsu  out  1  current/last owner: 1 = LSU, 0 = IFU

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: if any req_valid, pick winner; assert that master's req_ready combinationally this cycle; capture addr/wen/wdata/wstrb into registers (IFU: wen=0, wdata=0, wstrb=0); set grant_lsu; go to REQ. No valid: stay.
- REQ: mem_req_valid=1 driven from captured fields; fields held stable until mem_req_ready=1, then go to WAIT. mem_resp_valid ignored in REQ.
- WAIT: on mem_resp_valid, assert owner's resp_valid (combinational pass-through) and route mem_rdata to owner's rdata; go to IDLE.
- ifu_rdata/lsu_rdata = mem_rdata whenever the owner matches; value meaningful only with resp_valid.
- Non-owner's req_ready and resp_valid are always 0.
- Masters must hold req_valid and fields stable until req_ready; arbiter never drops an accepted request.
- Tie-break (both valid in IDLE): fixed priority, LSU wins (see Configuration).

## Timing
- Reset values: state IDLE, all req_ready/resp_valid/mem_req_valid 0, captured fields 0, grant_lsu 0.
- Accept at cycle N (IDLE), mem_req_valid high from N+1.
- Minimum transaction: 3 cycles (IDLE accept, REQ with mem_req_ready=1, WAIT with mem_resp_valid=1); next accept possible in the cycle after the response.
- Memory must not respond in the same cycle it accepts the request.
- Stall in REQ or WAIT is unbounded; no timeout.
- A request arriving while not IDLE waits. Its req_ready stays 0 until the next IDLE.
- rst in any state: next cycle IDLE, outstanding transaction abandoned, no resp_valid emitted. The memory shares rst.
- rst has priority over all handshakes in the same cycle.

## Configuration
- YSYX_23060286_ARB_RR_EN defined: round-robin. On a tie, the master not granted last wins. The last-grant register resets to LSU, so IFU wins the first tie. A single requester is always granted.
- Undefined: fixed priority, LSU always wins ties. No last-grant register exists.

## Test plan
- Single fetch: ifu_req_valid with addr 0x80000000, mem_req_ready=1 immediately, mem_resp_valid one cycle later with rdata 0x00000513 -> ifu_req_ready pulse at cycle 0, mem_addr=0x80000000 with mem_wen=0 at cycle 1, ifu_resp_valid with ifu_rdata=0x00000513 at cycle 2, lsu_resp_valid stays 0.
- Store: lsu store to addr 0x80001000, wdata 0xDEADBEEF, wstrb 4'b0011 -> mem_wen=1 and fields exact. mem_req_ready held 0 for 4 cycles: fields stable, mem_req_valid high throughout. lsu_resp_valid is a single pulse on the response.
- Tie: both valid in the same IDLE cycle -> without macro, LSU first then IFU. With YSYX_23060286_ARB_RR_EN, IFU first then LSU; both held valid continuously, grants alternate IFU, LSU, IFU.
- Back-to-back fetches with immediate memory -> one accept every 3 cycles, no bubbles beyond that, rdata routed to IFU each time.
- Reset in WAIT: assert rst one cycle while awaiting response -> state IDLE, no resp_valid pulse, next request processed normally.
- Early response: mem_resp_valid asserted during REQ -> ignored, no resp_valid pulse to either master.
